// File: rtl/remote_cmd_seq_pkg.sv
// Shared types and codes for the RemoteComm command sequencer.
package remote_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    SEND,
    WAIT_SENT,
    WAIT_RESP,
    NEXT,
    DONE
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_RDY_TO   = 2'b01;
  localparam logic [1:0] ERR_RESP_TO  = 2'b10;
  localparam logic [1:0] ERR_BAD_RESP = 2'b11;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;

  // Index width for a list of n entries, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/remote_cmd_seq_timer.sv
// Saturating up-counter shared by all wait states; flags expiry at limit_i.
module seq_timeout_timer
  import remote_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over counting; the count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= limit_i);

endmodule

// File: rtl/remote_cmd_seq.sv
// Issues a list of commands to RemoteComm after setup-ready and checks each ack.
module remote_cmd_seq
  import remote_seq_pkg::*;
#(
  parameter int NUM_CMDS     = 4,
  parameter int CMD_W        = 16,
  parameter int RESP_W       = 8,
  parameter logic [RESP_W-1:0] ACK_VAL = RESP_W'(ACK_DEFAULT),
  parameter int RDY_TIMEOUT  = 1000000,
  parameter int RESP_TIMEOUT = 4000000,
  parameter int CONT_ON_ERR  = 0,
  localparam int IDX_W       = idx_width(NUM_CMDS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic                      ready_in_i,
  input  logic [IDX_W:0]            num_cmds_i,
  input  logic [NUM_CMDS*CMD_W-1:0] cmd_list_i,
  output logic [CMD_W-1:0]          cmd_o,
  output logic                      send_cmd_o,
  input  logic                      cmd_sent_i,
  input  logic                      resp_rdy_i,
  input  logic [RESP_W-1:0]         resp_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [1:0]                err_code_o,
  output logic [IDX_W-1:0]          err_idx_o,
  output logic [IDX_W:0]            ack_cnt_o
);

  localparam int MAX_TO = (RDY_TIMEOUT > RESP_TIMEOUT) ? RDY_TIMEOUT : RESP_TIMEOUT;
  localparam int TMR_W  = $clog2(MAX_TO + 1);
  localparam logic [TMR_W-1:0] RDY_LIM  = TMR_W'(RDY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] RESP_LIM = TMR_W'(RESP_TIMEOUT - 1);
  localparam logic [IDX_W:0]   N_MAX    = (IDX_W+1)'(NUM_CMDS);

  state_e           state_q, state_d;
  logic [IDX_W:0]   n_q, n_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic [IDX_W:0]   ack_cnt_q, ack_cnt_d;
  logic             pass_q, pass_d;
  logic             resp_seen, fail;
  logic [1:0]       fail_code;
  logic             tmr_clear, tmr_en, tmr_expired;
  logic [TMR_W-1:0] tmr_limit;

  logic [CMD_W-1:0] cmd_tbl [NUM_CMDS];
  for (genvar i = 0; i < NUM_CMDS; i++) begin : g_tbl
    assign cmd_tbl[i] = cmd_list_i[i*CMD_W +: CMD_W];
  end

  // Sequencing, error capture and result bookkeeping; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    cmd_d      = cmd_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    ack_cnt_d  = ack_cnt_q;
    pass_d     = pass_q;
    resp_seen  = 1'b0;
    fail       = 1'b0;
    fail_code  = ERR_NONE;

    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            n_d        = (num_cmds_i > N_MAX) ? N_MAX : num_cmds_i;
            idx_d      = '0;
            err_code_d = ERR_NONE;
            err_idx_d  = '0;
            ack_cnt_d  = '0;
            pass_d     = 1'b0;
            state_d    = WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (ready_in_i) begin
            state_d = (n_q == '0) ? DONE : SEND;
          end else if (tmr_expired) begin
            fail      = 1'b1;
            fail_code = ERR_RDY_TO;
          end
        end
        SEND: state_d = WAIT_SENT;
        WAIT_SENT: begin
          if (cmd_sent_i) begin
            if (resp_rdy_i) resp_seen = 1'b1;
            else            state_d   = WAIT_RESP;
          end else if (tmr_expired) begin
            fail      = 1'b1;
            fail_code = ERR_RESP_TO;
          end
        end
        WAIT_RESP: begin
          if (resp_rdy_i) begin
            resp_seen = 1'b1;
          end else if (tmr_expired) begin
            fail      = 1'b1;
            fail_code = ERR_RESP_TO;
          end
        end
        NEXT: begin
          if ({1'b0, idx_q} == (n_q - 1'b1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SEND;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (resp_seen) begin
        if (resp_i == ACK_VAL) begin
          ack_cnt_d = ack_cnt_q + 1'b1;
          state_d   = NEXT;
        end else begin
          fail      = 1'b1;
          fail_code = ERR_BAD_RESP;
        end
      end

      // Only the first error of a run is recorded; a ready timeout always ends the run.
      if (fail) begin
        if (err_code_q == ERR_NONE) begin
          err_code_d = fail_code;
          err_idx_d  = idx_q;
        end
        state_d = ((CONT_ON_ERR != 0) && (fail_code != ERR_RDY_TO)) ? NEXT : DONE;
      end

      if (state_d == SEND) cmd_d = cmd_tbl[idx_d];

      if ((state_d == DONE) && (state_q != DONE)) begin
        pass_d = (err_code_d == ERR_NONE) && (ack_cnt_d == n_q);
      end
    end
  end

  // Timer restarts on every state change and only runs in the wait states.
  always_comb begin
    tmr_clear = (state_d != state_q);
    tmr_en    = (state_q == WAIT_RDY) || (state_q == WAIT_SENT) || (state_q == WAIT_RESP);
    tmr_limit = (state_q == WAIT_RDY) ? RDY_LIM : RESP_LIM;
  end

  seq_timeout_timer #(.CNT_W(TMR_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_en),
    .limit_i   (tmr_limit),
    .expired_o (tmr_expired)
  );

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      cmd_q      <= '0;
      err_code_q <= ERR_NONE;
      err_idx_q  <= '0;
      ack_cnt_q  <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      cmd_q      <= cmd_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
      ack_cnt_q  <= ack_cnt_d;
      pass_q     <= pass_d;
    end
  end

  assign cmd_o      = cmd_q;
  assign send_cmd_o = (state_q == SEND);
  assign busy_o     = (state_q != IDLE) && (state_q != DONE);
  assign done_o     = (state_q == DONE);
  assign pass_o     = pass_q;
  assign err_code_o = err_code_q;
  assign err_idx_o  = err_idx_q;
  assign ack_cnt_o  = ack_cnt_q;

endmodule

// File: tb/tb_remote_cmd_seq.sv
// Directed bench: two sequencers (stop-on-error and continue-on-error) share one RemoteComm model.
module tb_remote_cmd_seq;

  localparam int NC = 4;
  localparam int CW = 16;
  localparam int RW = 8;
  localparam int IW = 2;
  localparam int M_NORMAL = 0;
  localparam int M_SILENT = 1;
  localparam int M_COINC  = 2;
  localparam int M_NORESP = 3;

  logic clk, rst, start, abort, ready_in, cmd_sent, resp_rdy;
  logic [IW:0]      num_cmds;
  logic [NC*CW-1:0] cmd_list;
  logic [RW-1:0]    resp;

  logic [CW-1:0] cmd0, cmd1;
  logic          send0, send1, busy0, busy1, done0, done1, pass0, pass1;
  logic [1:0]    err0, err1;
  logic [IW-1:0] eidx0, eidx1;
  logic [IW:0]   ack0, ack1;

  int n_checks = 0;
  int n_pass   = 0;
  int nsend0 = 0, nsend1 = 0, ndone0 = 0, ndone1 = 0;
  int b0, b1, db0, db1;
  int mode;
  int mk;
  logic [RW-1:0] tbl [4];
  logic [CW-1:0] hist1 [64];

  remote_cmd_seq #(.NUM_CMDS(NC), .CMD_W(CW), .RESP_W(RW), .ACK_VAL(8'hA5),
                   .RDY_TIMEOUT(100), .RESP_TIMEOUT(200), .CONT_ON_ERR(0)) dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .ready_in_i(ready_in),
    .num_cmds_i(num_cmds), .cmd_list_i(cmd_list), .cmd_o(cmd0), .send_cmd_o(send0),
    .cmd_sent_i(cmd_sent), .resp_rdy_i(resp_rdy), .resp_i(resp), .busy_o(busy0),
    .done_o(done0), .pass_o(pass0), .err_code_o(err0), .err_idx_o(eidx0), .ack_cnt_o(ack0));

  remote_cmd_seq #(.NUM_CMDS(NC), .CMD_W(CW), .RESP_W(RW), .ACK_VAL(8'hA5),
                   .RDY_TIMEOUT(100), .RESP_TIMEOUT(200), .CONT_ON_ERR(1)) dut_c (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .ready_in_i(ready_in),
    .num_cmds_i(num_cmds), .cmd_list_i(cmd_list), .cmd_o(cmd1), .send_cmd_o(send1),
    .cmd_sent_i(cmd_sent), .resp_rdy_i(resp_rdy), .resp_i(resp), .busy_o(busy1),
    .done_o(done1), .pass_o(pass1), .err_code_o(err1), .err_idx_o(eidx1), .ack_cnt_o(ack1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event log: send strobes, done pulses and the commands seen by the continue-on-error unit.
  always @(posedge clk) begin
    if (send0) nsend0 <= nsend0 + 1;
    if (send1) begin
      nsend1 <= nsend1 + 1;
      hist1[nsend1 & 63] <= cmd1;
    end
    if (done0) ndone0 <= ndone0 + 1;
    if (done1) ndone1 <= ndone1 + 1;
  end

  // RemoteComm model: cmd_sent two cycles after a send, response one cycle later.
  initial begin
    cmd_sent = 1'b0;
    resp_rdy = 1'b0;
    resp     = '0;
    forever begin
      @(negedge clk);
      if ((send0 || send1) && (mode != M_SILENT)) begin
        mk = (nsend1 - b1) & 3;
        repeat (2) @(negedge clk);
        cmd_sent = 1'b1;
        if (mode == M_COINC) begin
          resp_rdy = 1'b1;
          resp     = tbl[mk];
        end
        @(negedge clk);
        cmd_sent = 1'b0;
        resp_rdy = 1'b0;
        if (mode == M_NORMAL) begin
          @(negedge clk);
          resp_rdy = 1'b1;
          resp     = tbl[mk];
          @(negedge clk);
          resp_rdy = 1'b0;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_res(input string tag, input int g, input int ep, input int ee,
                           input int ei, input int ea, input int es);
    check({tag, "/pass"},  32'(g != 0 ? pass1 : pass0), ep);
    check({tag, "/err"},   32'(g != 0 ? err1 : err0), ee);
    check({tag, "/eidx"},  32'(g != 0 ? eidx1 : eidx0), ei);
    check({tag, "/ack"},   32'(g != 0 ? ack1 : ack0), ea);
    check({tag, "/sends"}, (g != 0) ? (nsend1 - b1) : (nsend0 - b0), es);
    check({tag, "/dones"}, (g != 0) ? (ndone1 - db1) : (ndone0 - db0), 1);
  endtask

  task automatic snap();
    b0 = nsend0; b1 = nsend1; db0 = ndone0; db1 = ndone1;
  endtask

  task automatic do_start(input logic [IW:0] n);
    @(negedge clk);
    num_cmds = n;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit s0, s1;
    int c;
    s0 = 1'b0; s1 = 1'b0; c = 0;
    while (!(s0 && s1) && (c < budget)) begin
      if (done0) s0 = 1'b1;
      if (done1) s1 = 1'b1;
      if (!(s0 && s1)) begin
        @(negedge clk);
        c++;
      end
    end
    check({tag, "/done_seen"}, 32'(s0 && s1), 1);
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_ack1(input int budget);
    int c;
    c = 0;
    while ((ack0 != 1) && (c < budget)) begin
      @(negedge clk);
      c++;
    end
    check("ack1_reached", 32'(ack0), 1);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready_in = 1'b0;
    num_cmds = '0; cmd_list = '0; mode = M_NORMAL;
    b0 = 0; b1 = 0; db0 = 0; db1 = 0;
    for (int i = 0; i < 4; i++) tbl[i] = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst/busy", 32'(busy0), 0);
    check("rst/done", 32'(done0), 0);
    check("rst/send", 32'(send0), 0);
    check("rst/cmd",  32'(cmd0), 0);
    check("rst/pass", 32'(pass0), 0);
    check("rst/err",  32'(err0), 0);
    check("rst/ack",  32'(ack0), 0);
    rst = 1'b0;

    // Single command, ready arrives late.
    cmd_list = {16'h0, 16'h0, 16'h0, 16'h2000};
    snap();
    do_start(3'd1);
    repeat (48) @(negedge clk);
    check("t1/busy_wait", 32'(busy0), 1);
    check("t1/no_send_before_rdy", nsend0 - b0, 0);
    ready_in = 1'b1;
    wait_done("t1", 300);
    check_res("t1", 0, 1, 0, 0, 1, 1);
    check("t1/hist", 32'(hist1[b1 & 63]), 32'h2000);
    check("t1/cmd_held", 32'(cmd0), 32'h2000);
    check("t1/busy_after", 32'(busy0), 0);

    // Ready never comes: timeout after 100 cycles of waiting.
    ready_in = 1'b0;
    snap();
    do_start(3'd1);
    lat = 1;
    while (!done0 && (lat < 400)) begin
      @(negedge clk);
      lat++;
    end
    check("t2/latency", lat, 101);
    check("t2/busy_at_done", 32'(busy0), 0);
    repeat (12) @(negedge clk);
    check_res("t2", 0, 0, 1, 0, 0, 0);
    check_res("t2c", 1, 0, 1, 0, 0, 0);

    // Bad second response: stop vs continue.
    ready_in = 1'b1;
    cmd_list = {16'h0, 16'h5002, 16'h4001, 16'h2000};
    tbl[0] = 8'hA5; tbl[1] = 8'h5A; tbl[2] = 8'hA5;
    snap();
    do_start(3'd3);
    lat = 1;
    while (!send0 && (lat < 20)) begin
      @(negedge clk);
      lat++;
    end
    check("t3/first_send_lat", lat, 2);
    wait_done("t3", 400);
    check_res("t3", 0, 0, 3, 1, 1, 2);
    check_res("t4", 1, 0, 3, 1, 2, 3);
    check("t4/hist2", 32'(hist1[(b1 + 1) & 63]), 32'h4001);
    check("t4/hist3", 32'(hist1[(b1 + 2) & 63]), 32'h5002);

    // cmd_sent never arrives.
    tbl[1] = 8'hA5;
    mode = M_SILENT;
    snap();
    do_start(3'd1);
    wait_done("t5a", 600);
    check_res("t5a", 0, 0, 2, 0, 0, 1);
    check_res("t5ac", 1, 0, 2, 0, 0, 1);

    // cmd_sent and resp_rdy in the same cycle.
    mode = M_COINC;
    snap();
    do_start(3'd1);
    wait_done("t5b", 300);
    check_res("t5b", 0, 1, 0, 0, 1, 1);

    // Zero commands: pass straight after ready.
    mode = M_NORMAL;
    snap();
    do_start(3'd0);
    wait_done("tz", 100);
    check_res("tz", 0, 1, 0, 0, 0, 0);

    // Oversized count is clamped to the list length.
    cmd_list = {16'h7003, 16'h5002, 16'h4001, 16'h2000};
    snap();
    do_start(3'd7);
    wait_done("tc", 400);
    check_res("tc", 0, 1, 0, 0, 4, 4);
    check("tc/cmd_last", 32'(cmd0), 32'h7003);

    // Abort while waiting for a response.
    mode = M_NORESP;
    snap();
    do_start(3'd2);
    repeat (8) @(negedge clk);
    check("t6/busy_pre_abort", 32'(busy0), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t6/busy_abort", 32'(busy0), 0);
    check("t6/busy_abort_c", 32'(busy1), 0);
    repeat (250) @(negedge clk);
    check("t6/no_done", ndone0 - db0, 0);
    check("t6/pass_abort", 32'(pass0), 0);
    check("t6/err_abort", 32'(err0), 0);

    // Start while busy is ignored.
    mode = M_NORMAL;
    snap();
    do_start(3'd2);
    wait_ack1(100);
    do_start(3'd1);
    wait_done("t6s", 300);
    check_res("t6s", 0, 1, 0, 0, 2, 2);

    // Reset in the middle of a run.
    snap();
    do_start(3'd3);
    wait_ack1(100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6r/busy", 32'(busy0), 0);
    check("t6r/cmd",  32'(cmd0), 0);
    check("t6r/ack",  32'(ack0), 0);
    check("t6r/pass", 32'(pass0), 0);
    check("t6r/err",  32'(err0), 0);
    check("t6r/send", 32'(send0), 0);
    check("t6r/done", 32'(done0), 0);
    check("t6r/busy_c", 32'(busy1), 0);
    check("t6r/ack_c",  32'(ack1), 0);
    repeat (20) @(negedge clk);
    check("t6r/idle_after", 32'(busy0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/remote_cmd_seq.md
Name: remote_cmd_seq

Overview:
Synthesizable command sequencer that drives the RemoteComm command interface without a testbench.
- Waits for a setup-ready indication, with timeout.
- Issues a programmable list of 16-bit commands, one at a time.
- After each command, waits for the response and checks it against the positive-ack code.
- Reports pass/fail, the failing command index and an error code.

It sits between a boot/self-test controller and RemoteComm. It is the parametrised hardware successor to the init-and-calibrate check, generalised to N commands, configurable timeouts and continue-on-error mode.

Parameters:
NUM_CMDS, 4, maximum commands in the list (1..16)
CMD_W, 16, command width
RESP_W, 8, response width
ACK_VAL, 8'hA5, positive acknowledge code
RDY_TIMEOUT, 1000000, cycles to wait for ready_in before error
RESP_TIMEOUT, 4000000, cycles to wait for cmd_sent, then resp_rdy, per command
CONT_ON_ERR, 0, 1 = log the error and continue with the next command; 0 = stop at the first error

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; starts a run when idle
abort  in  1  returns to IDLE immediately; result marked fail
ready_in  in  1  setup-complete level, e.g. NEMO_setup
num_cmds  in  IDX_W+1  commands to run; sampled at start; clamped to NUM_CMDS
cmd_list  in  NUM_CMDS*CMD_W  flattened list; entry i = bits [i*CMD_W +: CMD_W]; sampled per command
cmd  out  CMD_W  command to RemoteComm
send_cmd  out  1  one-cycle send strobe
cmd_sent  in  1  RemoteComm transmit complete
resp_rdy  in  1  response valid strobe
resp  in  RESP_W  response byte
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  one-cycle pulse at the end of a run
pass  out  1  1 = all commands acked; held until the next start
err_code  out  2  00 none, 01 ready timeout, 10 response timeout, 11 bad response; holds the first error
err_idx  out  IDX_W  index of the first failing command
ack_cnt  out  IDX_W+1  count of commands acked this run

IDX_W = clog2(NUM_CMDS), minimum 1.

Behaviour:
- Reset: state IDLE; all outputs 0 (cmd=0, send_cmd=0, busy=0, done=0, pass=0, err_code=0, err_idx=0, ack_cnt=0).
- IDLE:
  - start=1 latches n = min(num_cmds, NUM_CMDS).
  - Clears err_code, err_idx, ack_cnt and pass, then moves to WAIT_RDY.
  - start while busy is ignored.
- WAIT_RDY:
  - ready_in=1 -> SEND; zero extra latency if ready_in is already high.
  - Timer reaches RDY_TIMEOUT-1 -> err_code=01, DONE (regardless of CONT_ON_ERR).
  - If n=0: go to DONE with pass=1 after ready.
- SEND:
  - cmd <= cmd_list[idx]; send_cmd=1 for exactly one cycle.
  - cmd is held stable until the next SEND.
  - Next state WAIT_SENT; timer cleared.
- WAIT_SENT:
  - cmd_sent=1 -> WAIT_RESP; timer cleared.
  - If resp_rdy is asserted in the same cycle, it is consumed as the response and evaluated directly.
  - Timeout -> error 10.
- WAIT_RESP:
  - resp_rdy=1 and resp==ACK_VAL -> ack_cnt++.
  - resp_rdy=1 and resp!=ACK_VAL -> error 11.
  - Timeout at RESP_TIMEOUT-1 -> error 10.
- Error handling:
  - First error only: latch err_code and err_idx=idx.
  - CONT_ON_ERR=0 -> DONE.
  - CONT_ON_ERR=1 -> NEXT.
- NEXT:
  - idx == n-1 -> DONE; otherwise idx++ and go to SEND.
  - Gap of one idle cycle between consecutive send_cmd strobes minimum.
- DONE:
  - done=1 for one cycle; pass = (err_code==00 && ack_cnt==n).
  - busy drops in the same cycle; next state IDLE.
- abort (any non-IDLE state):
  - Next cycle IDLE; no done pulse; pass=0; err fields retain values.
  - abort has priority over all other events.
- resp_rdy outside WAIT_SENT/WAIT_RESP is ignored.
- rst mid-run: all state and outputs return to reset values next cycle.
- Timer: single down/up counter sized for max(RDY_TIMEOUT, RESP_TIMEOUT); saturates; no wrap.

Decomposition:
- Package remote_seq_pkg: state enum (IDLE, WAIT_RDY, SEND, WAIT_SENT, WAIT_RESP, NEXT, DONE), err_code localparams (ERR_NONE, ERR_RDY_TO, ERR_RESP_TO, ERR_BAD_RESP), default ACK_VAL.
- One natural sub-module: seq_timeout_timer (clear, enable, limit input, expired output), reused per wait state.

Test Plan:
1. NUM_CMDS=4, num_cmds=1, cmd_list[0]=16'h2000, ready_in rises at cycle 50, RemoteComm model acks 8'hA5 -> one send_cmd with cmd=16'h2000; done; pass=1; err_code=00; ack_cnt=1.
2. ready_in held 0, RDY_TIMEOUT=100 -> done at ~cycle 101 after start; err_code=01; pass=0; no send_cmd.
3. num_cmds=3 {16'h2000, 16'h4001, 16'h5002}, second response 8'h5A, CONT_ON_ERR=0 -> two sends; err_code=11; err_idx=1; ack_cnt=1; pass=0.
4. Same stimulus with CONT_ON_ERR=1 -> three sends; err_code=11; err_idx=1; ack_cnt=2; pass=0.
5. cmd_sent never asserted, RESP_TIMEOUT=200 -> err_code=10, err_idx=0. Then a separate run where cmd_sent and resp_rdy (8'hA5) coincide -> accepted, pass=1.
6. abort asserted in WAIT_RESP -> IDLE next cycle, no done, busy=0. start during busy is ignored. rst mid-run -> all outputs 0.
